// File: rtl/covox_sd_dac_pkg.sv
// Shared constants for the covox DAC path and the future beeper/tape
// filter stages that will share the same idle-width default.
package covox_sd_dac_pkg;

    localparam int          COVOX_WIDTH     = 8;
    localparam logic [7:0]  COVOX_MID       = 8'h80;
    localparam int          COVOX_IDLE_BITS = 16;

endpackage : covox_sd_dac_pkg

// File: rtl/covox_sd_dac_sd_mod1.sv
// First-order sigma-delta modulator: the carry out of a WIDTH-bit
// phase accumulator is the output bit, so the bit density equals
// code / 2**WIDTH.
module sd_mod1 #(
    parameter int WIDTH = 8
) (
    input  logic             cpu_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] code,
    output logic             sd_bit
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, code};

    // Accumulate the code every cycle; the carry becomes the output bit.
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            acc    <= '0;
            sd_bit <= 1'b0;
        end else begin
            acc    <= sum[WIDTH-1:0];
            sd_bit <= sum[WIDTH];
        end
    end

endmodule : sd_mod1

// File: rtl/covox_sd_dac.sv
// Covox port DAC: captures the byte the CPU writes to the covox port on
// the rising edge of the decoder strobe and plays it out as a 1-bit
// sigma-delta stream for an external RC filter. Single clock domain
// (cpu_clock).
//
// Build option COVOX_IDLE_MUTE_EN: after 2**IDLE_BITS-1 cycles without a
// write the applied code is forced to MID_CODE and mute_active goes high
// until the next write. Without it the last written code is held forever
// and mute_active is tied low.
module covox_sd_dac
    import covox_sd_dac_pkg::*;
#(
    parameter int               WIDTH     = COVOX_WIDTH,
    parameter logic [WIDTH-1:0] MID_CODE  = WIDTH'(COVOX_MID),
    parameter int               IDLE_BITS = COVOX_IDLE_BITS
) (
    input  logic             cpu_clock,
    input  logic             reset,
    input  logic             covox_we,
    input  logic [WIDTH-1:0] d,
    output logic             dac_out,
    output logic [WIDTH-1:0] sample_q,
    output logic             sample_stb,
    output logic             mute_active
);

    logic             we_s0;
    logic             we_s1;
    logic [WIDTH-1:0] d_s0;
    logic             capture;

    // Strobe and data are registered on the same edge, so the captured
    // byte is the one present on the first high sample of the strobe.
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            we_s0 <= 1'b0;
            we_s1 <= 1'b0;
            d_s0  <= '0;
        end else begin
            we_s0 <= covox_we;
            we_s1 <= we_s0;
            d_s0  <= d;
        end
    end

    // Rising edge of the registered strobe; a long strobe captures once.
    assign capture = we_s0 & ~we_s1;

`ifdef COVOX_IDLE_MUTE_EN
    logic [IDLE_BITS-1:0] idle_cnt;
    logic                 idle_full;
    logic                 mute_q;

    assign idle_full = &idle_cnt;

    // Capture the new code, or fall back to midscale once the idle
    // counter has saturated; a capture always wins over the mute.
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            sample_q   <= MID_CODE;
            sample_stb <= 1'b0;
            idle_cnt   <= '0;
            mute_q     <= 1'b0;
        end else begin
            sample_stb <= capture;
            if (capture) begin
                sample_q <= d_s0;
                idle_cnt <= '0;
                mute_q   <= 1'b0;
            end else if (!idle_full) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                sample_q <= MID_CODE;
                mute_q   <= 1'b1;
            end
        end
    end

    assign mute_active = mute_q;
`else
    // Capture the new code and pulse the strobe; the code is held otherwise.
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            sample_q   <= MID_CODE;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= capture;
            if (capture) begin
                sample_q <= d_s0;
            end
        end
    end

    // The idle width only matters when the mute is built in.
    logic unused_idle_bits;
    assign unused_idle_bits = (IDLE_BITS > 0);

    assign mute_active = 1'b0;
`endif

    // The modulator sees the registered code, so a new sample takes
    // effect the cycle after capture without clearing the accumulator.
    sd_mod1 #(
        .WIDTH (WIDTH)
    ) u_sd_mod1 (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .code      (sample_q),
        .sd_bit    (dac_out)
    );

endmodule : covox_sd_dac

// File: tb/tb_covox_sd_dac.sv
// Self-checking bench for covox_sd_dac. Writes push the expected code
// into a queue; a monitor pops and compares whenever sample_stb fires.
module tb_covox_sd_dac;

`ifdef COVOX_IDLE_MUTE_EN
    localparam int TB_IDLE_BITS = 4;
`else
    localparam int TB_IDLE_BITS = 16;
`endif

    logic       cpu_clock = 1'b0;
    logic       reset     = 1'b1;
    logic       covox_we  = 1'b0;
    logic [7:0] d         = 8'h00;
    logic       dac_out;
    logic [7:0] sample_q;
    logic       sample_stb;
    logic       mute_active;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    covox_sd_dac #(
        .WIDTH     (8),
        .MID_CODE  (8'h80),
        .IDLE_BITS (TB_IDLE_BITS)
    ) dut (
        .cpu_clock   (cpu_clock),
        .reset       (reset),
        .covox_we    (covox_we),
        .d           (d),
        .dac_out     (dac_out),
        .sample_q    (sample_q),
        .sample_stb  (sample_stb),
        .mute_active (mute_active)
    );

    always #5 cpu_clock = ~cpu_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding write.
    initial begin
        forever begin
            @(negedge cpu_clock);
            if (!reset && sample_stb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_stb", 32'(sample_q), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("capture_value", 32'(sample_q), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Strobe high for 'hold' samples; d changes after the first sample
    // and must not affect the captured value. stb must pulse exactly once,
    // on the second edge after the strobe is first driven.
    task automatic write_byte(input logic [7:0] v, input int hold);
        @(negedge cpu_clock);
        covox_we = 1'b1;
        d        = v;
        exp_q.push_back(v);
        for (int i = 0; i < hold + 2; i++) begin
            @(negedge cpu_clock);
            if (i == 0) d = ~v;
            if (i == hold - 1) covox_we = 1'b0;
            check("stb_timing", 32'(sample_stb), (i == 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge cpu_clock);
            ones += int'(dac_out);
        end
    endtask

    task automatic check_alternation(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge cpu_clock);
            check("mid_alternation", 32'(dac_out), 32'(i % 2));
        end
    endtask

    initial begin
        int ones;
        int found;

        // Reset for 3 cycles.
        repeat (3) @(negedge cpu_clock);
        check("reset_sample_q", 32'(sample_q), 32'h80);
        check("reset_mute", 32'(mute_active), 32'd0);
        check("reset_stb", 32'(sample_stb), 32'd0);
        check("reset_dac", 32'(dac_out), 32'd0);
        reset = 1'b0;
        check_alternation(8);

        // Strobe held for 3 cycles.
        write_byte(8'h40, 3);
        check("hold_sample_q", 32'(sample_q), 32'h40);
`ifndef COVOX_IDLE_MUTE_EN
        count_ones(256, ones);
        check("density_40", 32'(ones), 32'd64);
`endif

        write_byte(8'h00, 1);
        check("zero_sample_q", 32'(sample_q), 32'h00);
`ifndef COVOX_IDLE_MUTE_EN
        count_ones(256, ones);
        check("density_00", 32'(ones), 32'd0);
`endif

        write_byte(8'hFF, 2);
        check("ff_sample_q", 32'(sample_q), 32'hFF);
`ifndef COVOX_IDLE_MUTE_EN
        count_ones(256, ones);
        check("density_ff", 32'(ones), 32'd255);
`endif

        // Single-sample strobe, then a long strobe with changing data.
        write_byte(8'hC3, 1);
        check("single_sample_q", 32'(sample_q), 32'hC3);
        write_byte(8'h5A, 4);
        check("long_hold_sample_q", 32'(sample_q), 32'h5A);

        // Back-to-back strobes separated by one low sample.
        @(negedge cpu_clock);
        covox_we = 1'b1; d = 8'h11; exp_q.push_back(8'h11);
        @(negedge cpu_clock);
        covox_we = 1'b0;
        @(negedge cpu_clock);
        check("b2b_first_stb", 32'(sample_stb), 32'd1);
        covox_we = 1'b1; d = 8'h22; exp_q.push_back(8'h22);
        @(negedge cpu_clock);
        covox_we = 1'b0;
        @(negedge cpu_clock);
        check("b2b_second_stb", 32'(sample_stb), 32'd1);
        repeat (2) @(negedge cpu_clock);
        check("b2b_sample_q", 32'(sample_q), 32'h22);

`ifndef COVOX_IDLE_MUTE_EN
        repeat (300) @(negedge cpu_clock);
        check("idle_hold_sample_q", 32'(sample_q), 32'h22);
        check("idle_no_mute", 32'(mute_active), 32'd0);
`endif

        // Reset lands on the capture edge: reset must win.
        @(negedge cpu_clock);
        covox_we = 1'b1; d = 8'h10;
        @(negedge cpu_clock);
        reset = 1'b1; covox_we = 1'b0;
        @(negedge cpu_clock);
        check("collide_stb", 32'(sample_stb), 32'd0);
        check("collide_sample_q", 32'(sample_q), 32'h80);
        reset = 1'b0;
        check_alternation(6);
        check("collide_after_q", 32'(sample_q), 32'h80);

`ifdef COVOX_IDLE_MUTE_EN
        write_byte(8'h20, 1);
        check("pre_mute_sample_q", 32'(sample_q), 32'h20);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge cpu_clock);
            if (mute_active === 1'b1) found = 1;
        end
        check("mute_reached", 32'(found), 32'd1);
        check("mute_sample_q", 32'(sample_q), 32'h80);
        write_byte(8'h55, 1);
        check("unmute_flag", 32'(mute_active), 32'd0);
        check("unmute_sample_q", 32'(sample_q), 32'h55);
`else
        found = 0;
        check("mute_tied_low", 32'(mute_active), 32'(found));
`endif

        repeat (4) @(negedge cpu_clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_covox_sd_dac
